d_fifo_drain_arbiter: RTL and testbench
=======================================

// Module: d_fifo_drain_arbiter
// PURPOSE
//  Downstream stage of full_logic. Drains the D0/D1 destination FIFOs by round-robin pop arbitration.
//  Merges them into one registered output stream with valid/ready handshake and a source tag.
//  Pops are issued only while full_logic reports its active state; no word is lost under backpressure.
// PARAMETERS
//  DATA_WIDTH  6  width of FIFO words and data_out
//  CNT_WIDTH   5  width of per-source delivered-word counters (DRAIN_COUNTERS_EN only)
// PORTS
//  clk            in   1           single clock, all logic on posedge
//  reset          in   1           synchronous, active-high; clears all state
//  active_in      in   1           full_logic FSM in ACTIVE state; gates new pops
//  empty_fifo_D0  in   1           D0 FIFO empty
//  empty_fifo_D1  in   1           D1 FIFO empty
//  data_out_D0    in   DATA_WIDTH  D0 FIFO read data, valid the cycle after D0_pop
//  data_out_D1    in   DATA_WIDTH  D1 FIFO read data, valid the cycle after D1_pop
//  D0_pop         out  1           pop request to D0 FIFO
//  D1_pop         out  1           pop request to D1 FIFO
//  data_out       out  DATA_WIDTH  merged output word (registered)
//  valid_out      out  1           data_out/src_out valid
//  out_ready      in   1           consumer accepts word when valid_out & out_ready
//  src_out        out  1           0 = word came from D0, 1 = from D1
//  cnt_D0, cnt_D1 out  CNT_WIDTH   delivered-word counters (DRAIN_COUNTERS_EN only)
// BEHAVIOUR
//  - Reset values: D0_pop=D1_pop=0, data_out=0, valid_out=0, src_out=0, skid empty, no pop in flight,
//    last_grant=1 (D0 wins first contention), state=IDLE, counters=0.
//  - Read latency: pop at cycle t -> FIFO word sampled at t+1 into output reg (or skid if output held).
//  - Storage: output reg + 1-entry skid. occ = valid_out + skid_valid + inflight.
//    Pop allowed in cycle t iff state==DRAIN and occ - (valid_out & out_ready) < 2.
//  - D0_pop/D1_pop: combinational from registered state and current empty inputs; at most one per cycle;
//    never asserted while matching empty_fifo_Dx=1.
//  - Arbitration: only one non-empty -> grant it. Both non-empty -> grant the one != last_grant.
//    last_grant updates only on an issued pop.
//  - Output order: skid drains into output reg before any newly arriving word; FIFO order kept per source.
//  - Full throughput 1 word/cycle when out_ready=1 steady; out_ready=0 stops pops after storage fills,
//    with data_out/src_out stable while valid_out=1 and out_ready=0.
//  - FSM: IDLE -> DRAIN when active_in=1. DRAIN -> FLUSH when active_in=0.
//    FLUSH: no new pops; in-flight/held words still delivered; FLUSH -> IDLE when occ==0.
//    FLUSH -> DRAIN if active_in=1 again. IDLE issues no pops.
//  - Both FIFOs empty in DRAIN: no pop, stay DRAIN; resume next cycle a FIFO goes non-empty.
//  - Reset mid-operation: in-flight word and skid contents discarded, valid_out drops next edge.
// CONFIGURATION
//  DRAIN_COUNTERS_EN defined: cnt_D0/cnt_D1 ports present.
//    Increment on valid_out & out_ready for the matching src_out; saturate at all-ones; cleared by reset.
//  Not defined: counter ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package: DATA_WIDTH default, FSM state encoding (IDLE/DRAIN/FLUSH), SRC_D0/SRC_D1 constants.
//  Sub-module: drain_skid_buffer (output reg + 1 skid entry, valid/ready, occupancy out);
//    arbiter + FSM stay in top.
// TESTING
//  1 D0 holds 3 words, D1 empty, active_in=1, out_ready=1
//    -> D0_pop 3 consecutive cycles, 3 words out, src_out=0, in order.
//  2 Both hold 2 words (D0:08,15 D1:04,16), out_ready=1
//    -> output sequence 08,04,15,16 with src 0,1,0,1.
//  3 D0 holds 5 words, out_ready=0 from start
//    -> exactly 2 pops, then D0_pop=0. out_ready=1 -> remaining 3 popped, all 5 out, none lost/duplicated.
//  4 active_in drops the cycle after a pop
//    -> no further pops, in-flight word still delivered, FSM reaches IDLE, valid_out=0.
//  5 reset=1 mid-stream with skid full
//    -> next cycle valid_out=0, pops=0, counters 0, D0 wins next contention.
//  6 DRAIN_COUNTERS_EN, CNT_WIDTH=2, 5 words from D1 delivered -> cnt_D1=3 (saturated), cnt_D0=0.

Source files
------------

// File: rtl/d_fifo_drain_arbiter_pkg.sv
// Shared definitions for the D0/D1 drain arbiter: default widths, FSM encoding, source tags.
package d_fifo_drain_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int CNT_WIDTH_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/d_fifo_drain_arbiter_skid.sv
// Output register plus one skid entry with valid/ready; reports how many words it holds.
module drain_skid_buffer
  import d_fifo_drain_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_src,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  output logic [1:0]            held_cnt
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_src_q, out_src_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_src_q, skid_src_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_src_d   = skid_src_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid word always goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_src_d    = skid_src_q;
        skid_valid_d = in_valid;
        if (in_valid) begin
          skid_data_d = in_data;
          skid_src_d  = in_src;
        end
      end else if (in_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_src_d   = in_src;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_src_d   = in_src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= SRC_D0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_src_q   <= SRC_D0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_src_q   <= skid_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign held_cnt  = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/d_fifo_drain_arbiter.sv
// Round-robin drain of the D0/D1 FIFOs into one tagged valid/ready stream.
// Optional per-source delivered-word counters when DRAIN_COUNTERS_EN is defined.
module d_fifo_drain_arbiter
  import d_fifo_drain_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef DRAIN_COUNTERS_EN
  , parameter int CNT_WIDTH = CNT_WIDTH_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic [DATA_WIDTH-1:0] data_out_D0,
  input  logic [DATA_WIDTH-1:0] data_out_D1,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic                  src_out
`ifdef DRAIN_COUNTERS_EN
  , output logic [CNT_WIDTH-1:0] cnt_D0
  , output logic [CNT_WIDTH-1:0] cnt_D1
`endif
);

  drain_state_e state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         inflight_q, inflight_d;
  logic         inflight_src_q, inflight_src_d;

  logic [1:0]            held_cnt, occ, occ_net;
  logic                  fire, pop_ok, grant_src, pop0, pop1;
  logic [DATA_WIDTH-1:0] arr_data;

  assign fire     = valid_out & out_ready;
  assign occ      = held_cnt + {1'b0, inflight_q};
  assign occ_net  = occ - {1'b0, fire};
  // active_in is also checked directly so no pop slips out in the cycle it falls.
  assign pop_ok   = !reset && active_in && (state_q == ST_DRAIN) && (occ_net < 2'd2);
  assign arr_data = (inflight_src_q == SRC_D1) ? data_out_D1 : data_out_D0;

  always_comb begin
    pop0      = 1'b0;
    pop1      = 1'b0;
    grant_src = last_grant_q;
    if (pop_ok) begin
      if (!empty_fifo_D0 && !empty_fifo_D1) begin
        grant_src = (last_grant_q == SRC_D0) ? SRC_D1 : SRC_D0;
      end else if (!empty_fifo_D0) begin
        grant_src = SRC_D0;
      end else if (!empty_fifo_D1) begin
        grant_src = SRC_D1;
      end
      pop0 = !empty_fifo_D0 && (grant_src == SRC_D0);
      pop1 = !empty_fifo_D1 && (grant_src == SRC_D1);
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = (pop0 || pop1) ? grant_src : last_grant_q;
    inflight_d     = pop0 || pop1;
    inflight_src_d = pop1;
    case (state_q)
      ST_IDLE:  if (active_in) state_d = ST_DRAIN;
      ST_DRAIN: if (!active_in) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (active_in) state_d = ST_DRAIN;
        else if (occ == 2'd0) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= SRC_D1;
      inflight_q     <= 1'b0;
      inflight_src_q <= SRC_D0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
    end
  end

  drain_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (arr_data),
    .in_src    (inflight_src_q),
    .out_ready (out_ready),
    .out_valid (valid_out),
    .out_data  (data_out),
    .out_src   (src_out),
    .held_cnt  (held_cnt)
  );

  assign D0_pop = pop0;
  assign D1_pop = pop1;

`ifdef DRAIN_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cnt_d0_q, cnt_d0_d, cnt_d1_q, cnt_d1_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    cnt_d0_d = cnt_d0_q;
    cnt_d1_d = cnt_d1_q;
    if (fire && (src_out == SRC_D0)) cnt_d0_d = sat_inc(cnt_d0_q);
    if (fire && (src_out == SRC_D1)) cnt_d1_d = sat_inc(cnt_d1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else begin
      cnt_d0_q <= cnt_d0_d;
      cnt_d1_q <= cnt_d1_d;
    end
  end

  assign cnt_D0 = cnt_d0_q;
  assign cnt_D1 = cnt_d1_q;
`endif

endmodule

// File: tb/tb_d_fifo_drain_arbiter.sv
// Scoreboard bench for d_fifo_drain_arbiter with behavioural D0/D1 FIFO models.
module tb_d_fifo_drain_arbiter;
  import d_fifo_drain_arbiter_pkg::*;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset, active_in, empty_fifo_D0, empty_fifo_D1, out_ready;
  logic [DW-1:0] data_out_D0, data_out_D1, data_out;
  logic          D0_pop, D1_pop, valid_out, src_out;
`ifdef DRAIN_COUNTERS_EN
  logic [1:0]    cnt_D0, cnt_D1;
`endif

  always #5 clk = ~clk;

`ifdef DRAIN_COUNTERS_EN
  d_fifo_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out),
    .valid_out(valid_out), .out_ready(out_ready), .src_out(src_out),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1));
`else
  d_fifo_drain_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out),
    .valid_out(valid_out), .out_ready(out_ready), .src_out(src_out));
`endif

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } item_t;

  item_t         exp_q[$];
  item_t         mon_e;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            pops0 = 0;
  int            pops1 = 0;
  logic          hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push0(input logic [DW-1:0] v);
    q0.push_back(v);
    empty_fifo_D0 = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    q1.push_back(v);
    empty_fifo_D1 = 1'b0;
  endtask

  task automatic expect_w(input logic s, input logic [DW-1:0] d);
    item_t it;
    it.src  = s;
    it.data = d;
    exp_q.push_back(it);
  endtask

  // One clock: sample pop requests, then update the FIFO models (read data valid the cycle after a pop).
  task automatic step();
    logic p0, p1;
    #1;
    p0 = D0_pop;
    p1 = D1_pop;
    chk("pop_legal", 32'((p0 && p1) || (p0 && q0.size() == 0) || (p1 && q1.size() == 0)), 32'd0);
    if (p0) pops0++;
    if (p1) pops1++;
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) data_out_D0 = q0.pop_front();
    if (p1 && q1.size() > 0) data_out_D1 = q1.pop_front();
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    empty_fifo_D0 = 1'b1;
    empty_fifo_D1 = 1'b1;
    data_out_D0 = '0;
    data_out_D1 = '0;
    step();
    step();
    reset = 1'b0;
    pops0 = 0;
    pops1 = 0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || valid_out) && i < budget) begin
      step();
      i++;
    end
    chk("drain_timeout", 32'(exp_q.size() != 0 || valid_out), 32'd0);
  endtask

  // Monitor: scoreboard pops on every accepted word; held words must stay stable.
  initial begin
    forever begin
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", 32'(valid_out), 32'd1);
        chk("hold_word", 32'({src_out, data_out}), 32'({hold_src, hold_data}));
      end
      if (valid_out && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got src %0d data 0x%0h, required no word", src_out, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 32'(data_out), 32'(mon_e.data));
          chk("out_src", 32'(src_out), 32'(mon_e.src));
        end
      end
      hold      = valid_out && !out_ready && !reset;
      hold_data = data_out;
      hold_src  = src_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; active_in = 1'b0; out_ready = 1'b0;
    empty_fifo_D0 = 1'b1; empty_fifo_D1 = 1'b1;
    data_out_D0 = '0; data_out_D1 = '0;
    step();
    step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pops", 32'({D0_pop, D1_pop}), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_src", 32'(src_out), 32'd0);
    reset = 1'b0;

    // 1: three D0 words, D1 empty
    push0(6'h11); push0(6'h22); push0(6'h33);
    expect_w(1'b0, 6'h11); expect_w(1'b0, 6'h22); expect_w(1'b0, 6'h33);
    active_in = 1'b1; out_ready = 1'b1;
    #1 chk("t1_idle_nopop", 32'(D0_pop), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      #1 chk("t1_pop", 32'(D0_pop), 32'd1);
      step();
    end
    #1 chk("t1_pop_done", 32'(D0_pop), 32'd0);
    drain(10);
    chk("t1_pops", 32'(pops0), 32'd3);

    // 2: both sources, alternate starting with D0
    do_reset();
    push0(6'h08); push0(6'h15);
    push1(6'h04); push1(6'h16);
    expect_w(1'b0, 6'h08); expect_w(1'b1, 6'h04);
    expect_w(1'b0, 6'h15); expect_w(1'b1, 6'h16);
    drain(12);
    chk("t2_pops", 32'(pops0 * 10 + pops1), 32'd22);

    // 3: backpressure from the start
    out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push0(DW'(i));
      expect_w(1'b0, DW'(i));
    end
    repeat (6) step();
    #1;
    chk("t3_pops_stalled", 32'(pops0), 32'd2);
    chk("t3_pop_off", 32'(D0_pop), 32'd0);
    chk("t3_valid_held", 32'(valid_out), 32'd1);
    out_ready = 1'b1;
    drain(15);
    chk("t3_pops", 32'(pops0), 32'd5);

    // 4: active_in falls right after the first pop
    do_reset();
    push0(6'h2A); push0(6'h2B); push0(6'h2C);
    expect_w(1'b0, 6'h2A);
    step();
    #1 chk("t4_pop", 32'(D0_pop), 32'd1);
    step();
    active_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_nopop", 32'(D0_pop), 32'd0);
      step();
    end
    drain(10);
    step();
    chk("t4_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t4_valid", 32'(valid_out), 32'd0);
    chk("t4_pops", 32'(pops0), 32'd1);

    // 5: reset while output and skid are both full
    active_in = 1'b1; out_ready = 1'b0;
    do_reset();
    push0(6'h30); push0(6'h31); push0(6'h32);
    push1(6'h38); push1(6'h39); push1(6'h3A);
    repeat (5) step();
    #1;
    chk("t5_pops_before", 32'(pops0 * 10 + pops1), 32'd11);
    chk("t5_valid_before", 32'(valid_out), 32'd1);
    reset = 1'b1;
    #1 chk("t5_pop_in_rst", 32'({D0_pop, D1_pop}), 32'd0);
    step();
    chk("t5_valid_after", 32'(valid_out), 32'd0);
    chk("t5_data_after", 32'(data_out), 32'd0);
`ifdef DRAIN_COUNTERS_EN
    chk("t5_cnt", 32'({cnt_D0, cnt_D1}), 32'd0);
`endif
    reset = 1'b0; out_ready = 1'b1;
    expect_w(1'b0, 6'h31); expect_w(1'b1, 6'h39);
    expect_w(1'b0, 6'h32); expect_w(1'b1, 6'h3A);
    drain(15);

`ifdef DRAIN_COUNTERS_EN
    // 6: two-bit counter saturates after five D1 words
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push1(DW'(6'h20 + i));
      expect_w(1'b1, DW'(6'h20 + i));
    end
    drain(20);
    chk("t6_cnt_D1", 32'(cnt_D1), 32'd3);
    chk("t6_cnt_D0", 32'(cnt_D0), 32'd0);
`endif

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
